// File: rtl/urv_divider_seq_pkg.sv
// Shared definitions for the sequential RV32M divider.
// Holds the function codes seen on d_fun_i, the rd-source code the
// execute stage uses to select the divider result, and small decode helpers.
package urv_divider_seq_pkg;

    // d_fun_i encodings (funct3 of the M-extension divide group)
    localparam logic [2:0] FUNC_DIV  = 3'b100;
    localparam logic [2:0] FUNC_DIVU = 3'b101;
    localparam logic [2:0] FUNC_REM  = 3'b110;
    localparam logic [2:0] FUNC_REMU = 3'b111;

    // Execute-stage rd mux code selecting x_rd_o
    localparam logic [2:0] RD_SOURCE_DIVIDE = 3'b011;

    // DIV/REM are signed, DIVU/REMU unsigned
    function automatic logic fun_is_signed(input logic [2:0] fun);
        return !fun[0];
    endfunction

    // REM/REMU return the remainder, DIV/DIVU the quotient
    function automatic logic fun_is_rem(input logic [2:0] fun);
        return fun[1];
    endfunction

endpackage

// File: rtl/urv_divider_seq_div_step.sv
// urv_div_step: one combinational restoring-division step.
// Ports:
//   rem_i  partial remainder (g_width+1 bits, always < divisor)
//   div_i  divisor magnitude
//   bit_i  next dividend bit shifted into the remainder
//   rem_o  next partial remainder
//   q_o    quotient bit produced by this step
module urv_div_step #(
    parameter int g_width = 32
) (
    input  logic [g_width:0]   rem_i,
    input  logic [g_width-1:0] div_i,
    input  logic               bit_i,
    output logic [g_width:0]   rem_o,
    output logic               q_o
);

    // One extra bit above the shifted remainder catches the borrow.
    logic [g_width+1:0] diff;

    always_comb begin
        diff  = {rem_i, bit_i} - {2'b00, div_i};
        q_o   = !diff[g_width+1];
        rem_o = diff[g_width+1] ? {rem_i[g_width-1:0], bit_i} : diff[g_width:0];
    end

endmodule

// File: rtl/urv_divider_seq.sv
// urv_divider_seq: multi-cycle iterative divider for the execute stage
// (DIV/DIVU/REM/REMU). Retires g_bits_per_cycle quotient bits per cycle,
// stalls the pipeline while it works, then holds the result in DONE.
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   x_stall_i            pipeline stall from other units (holds DONE)
//   x_kill_i             cancel the X-stage instruction (abort to IDLE)
//   x_stall_req_o        divider stall request (combinational)
//   d_valid_i            X-stage instruction valid
//   d_is_divide_i        X-stage instruction is a divide
//   d_fun_i              function code (FUNC_* in the package)
//   d_rs1_i, d_rs2_i     dividend, divisor
//   x_rd_o               result, valid in DONE
module urv_divider_seq
    import urv_divider_seq_pkg::*;
#(
    parameter int g_width          = 32,
    parameter int g_bits_per_cycle = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               x_stall_i,
    input  logic               x_kill_i,
    output logic               x_stall_req_o,
    input  logic               d_valid_i,
    input  logic               d_is_divide_i,
    input  logic [2:0]         d_fun_i,
    input  logic [g_width-1:0] d_rs1_i,
    input  logic [g_width-1:0] d_rs2_i,
    output logic [g_width-1:0] x_rd_o
);

    localparam int N  = g_width / g_bits_per_cycle;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [g_width-1:0] MOST_NEG = {1'b1, {(g_width-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_FIXUP,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [g_width:0]   rem_q, rem_d;      // partial remainder
    logic [g_width-1:0] quo_q, quo_d;      // dividend shifts out, quotient shifts in
    logic [g_width-1:0] div_q, div_d;      // divisor magnitude
    logic [g_width-1:0] rs1_q, rs1_d;      // original rs1, needed for divide-by-zero
    logic [g_width-1:0] res_q, res_d;
    logic               negq_q, negq_d;
    logic               negr_q, negr_d;
    logic               isrem_q, isrem_d;
    logic               dbz_q, dbz_d;
    logic               ovf_q, ovf_d;

    logic               start;
    logic               sgn, rs1_neg, rs2_neg;
    logic [g_width-1:0] q_fix, r_fix;

    // d_fun_i[2] only tags the divide group; d_is_divide_i already qualifies it.
    logic unused_fun;
    assign unused_fun = d_fun_i[2];

    assign start   = d_valid_i & d_is_divide_i & !x_kill_i & (state_q == S_IDLE);
    assign sgn     = fun_is_signed(d_fun_i);
    assign rs1_neg = sgn & d_rs1_i[g_width-1];
    assign rs2_neg = sgn & d_rs2_i[g_width-1];

    assign x_stall_req_o = !x_kill_i &
                           (start | (state_q == S_BUSY) | (state_q == S_FIXUP));
    assign x_rd_o        = res_q;

    // Restoring-step chain: stage i consumes dividend bit W-1-i and produces
    // quotient bit B-1-i, so the first stage yields the most significant bit.
    logic [g_bits_per_cycle:0][g_width:0] chain;
    logic [g_bits_per_cycle-1:0]          qbits;

    assign chain[0] = rem_q;

    for (genvar i = 0; i < g_bits_per_cycle; i++) begin : g_step
        urv_div_step #(.g_width(g_width)) u_step (
            .rem_i (chain[i]),
            .div_i (div_q),
            .bit_i (quo_q[g_width-1-i]),
            .rem_o (chain[i+1]),
            .q_o   (qbits[g_bits_per_cycle-1-i])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        rs1_d   = rs1_q;
        res_d   = res_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        isrem_d = isrem_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;

        // Magnitude results are below 2^W, so bit W of rem_q is zero here.
        q_fix = negq_q ? -quo_q : quo_q;
        r_fix = negr_q ? -rem_q[g_width-1:0] : rem_q[g_width-1:0];
        if (dbz_q) begin
            q_fix = '1;
            r_fix = rs1_q;
        end else if (ovf_q) begin
            q_fix = MOST_NEG;
            r_fix = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // -MOST_NEG wraps to itself, which is the correct unsigned magnitude.
                    quo_d   = rs1_neg ? -d_rs1_i : d_rs1_i;
                    div_d   = rs2_neg ? -d_rs2_i : d_rs2_i;
                    rs1_d   = d_rs1_i;
                    negq_d  = rs1_neg ^ rs2_neg;
                    negr_d  = rs1_neg;
                    isrem_d = fun_is_rem(d_fun_i);
                    dbz_d   = (d_rs2_i == '0);
                    ovf_d   = sgn & (d_rs1_i == MOST_NEG) & (d_rs2_i == '1);
                    rem_d   = '0;
                    cnt_d   = CW'(N - 1);
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                rem_d = chain[g_bits_per_cycle];
                quo_d = (quo_q << g_bits_per_cycle) | g_width'(qbits);
                if (cnt_q == '0) state_d = S_FIXUP;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_FIXUP: begin
                res_d   = isrem_q ? r_fix : q_fix;
                state_d = S_DONE;
            end
            S_DONE: begin
                // Leaving on the edge where X/W captures x_rd_o prevents a restart.
                if (!x_stall_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (x_kill_i) state_d = S_IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            rs1_q   <= '0;
            res_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            isrem_q <= 1'b0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            rs1_q   <= rs1_d;
            res_q   <= res_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            isrem_q <= isrem_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_urv_divider_seq.sv
// Bench for urv_divider_seq: three instances (1, 2, 4 bits per cycle) share
// operand/control inputs, each has its own d_valid_i. A cycle-level model
// tracks cycles since issue per instance and the arithmetic result.
module tb_urv_divider_seq;
    import urv_divider_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        x_stall = 1'b0;
    logic        kill = 1'b0;
    logic        isdiv = 1'b1;
    logic [2:0]  fun = FUNC_DIVU;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        valid   [3];
    logic        stall_o [3];
    logic [31:0] rd_o    [3];

    int          ncmp = 0;
    int          nerr = 0;
    int          mcyc [3];
    logic [31:0] mres [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        urv_divider_seq #(.g_width(32), .g_bits_per_cycle(1 << g)) u_dut (
            .clk_i         (clk),
            .rst_i         (rst),
            .x_stall_i     (x_stall),
            .x_kill_i      (kill),
            .x_stall_req_o (stall_o[g]),
            .d_valid_i     (valid[g]),
            .d_is_divide_i (isdiv),
            .d_fun_i       (fun),
            .d_rs1_i       (rs1),
            .d_rs2_i       (rs2),
            .x_rd_o        (rd_o[g])
        );
    end

    function automatic int lat(input int k);
        return (32 >> k) + 2;
    endfunction

    // RV32M semantics straight from the ISA rules.
    function automatic logic [31:0] ref_div(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 0) begin
            q = '1; r = a;
        end else if (f == FUNC_DIV || f == FUNC_REM) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000; r = 0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b; r = a % b;
        end
        return (f == FUNC_REM || f == FUNC_REMU) ? r : q;
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s dut%0d t=%0t: got %h expected %h", name, k, $time, act, exp);
        end
    endtask

    // Model: -1 idle, otherwise cycles since issue (capped at DONE = lat).
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst || kill) mcyc[k] <= -1;
            else if (mcyc[k] < 0) begin
                if (valid[k] && isdiv) begin
                    mcyc[k] <= 1;
                    mres[k] <= ref_div(fun, rs1, rs2);
                end
            end else if (mcyc[k] < lat(k)) mcyc[k] <= mcyc[k] + 1;
            else if (!x_stall) mcyc[k] <= -1;
        end
    end

    // Compare every cycle outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                logic exp_st;
                if (kill)            exp_st = 1'b0;
                else if (mcyc[k] < 0) exp_st = valid[k] && isdiv;
                else                 exp_st = (mcyc[k] <= lat(k) - 1);
                check("stall_req", k, 32'(stall_o[k]), 32'(exp_st));
                if (!kill && mcyc[k] >= lat(k)) check("x_rd", k, rd_o[k], mres[k]);
            end
        end
    end

    // Precondition/postcondition: called and returns at posedge+1 of an idle cycle.
    task automatic op(input int k, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                      input int hold, input bit haslit, input logic [31:0] lit);
        int cnt = 0;
        fun = f; rs1 = a; rs2 = b; valid[k] = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!stall_o[k]) break;
            cnt++;
            @(posedge clk); #1;
            valid[k] = 1'b0;
        end
        valid[k] = 1'b0;
        check("latency", k, cnt, lat(k));
        if (haslit) check("result", k, rd_o[k], lit);
        if (hold > 0) begin
            x_stall = 1'b1;
            repeat (hold) begin @(posedge clk); #1; end
            check("held_rd", k, rd_o[k], lit);
            x_stall = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a, b, exp;
    } vec_t;

    vec_t vecs [12];

    initial begin
        vecs = '{
            '{FUNC_DIVU, 32'd100,        32'd7,          32'd14},
            '{FUNC_REMU, 32'd100,        32'd7,          32'd2},
            '{FUNC_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD},
            '{FUNC_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF},
            '{FUNC_REM,  32'd7,          32'hFFFF_FFFE,  32'd1},
            '{FUNC_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF},
            '{FUNC_REMU, 32'd5,          32'd0,          32'd5},
            '{FUNC_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000},
            '{FUNC_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0},
            '{FUNC_REM,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9},
            '{FUNC_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF},
            '{FUNC_DIVU, 32'd9,          32'd3,          32'd3}
        };
        for (int k = 0; k < 3; k++) valid[k] = 1'b0;

        // Pin the model to hand-computed values.
        for (int i = 0; i < 12; i++) check("model", i, ref_div(vecs[i].f, vecs[i].a, vecs[i].b), vecs[i].exp);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rst_stall", k, 32'(stall_o[k]), 32'd0);
            check("rst_rd", k, rd_o[k], 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors on every configuration
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 12; i++) op(k, vecs[i].f, vecs[i].a, vecs[i].b, 0, 1'b1, vecs[i].exp);

        // Hold DONE under x_stall, then issue in the very next cycle
        op(0, FUNC_DIVU, 32'd100, 32'd7, 5, 1'b1, 32'd14);
        op(0, FUNC_REMU, 32'd100, 32'd7, 0, 1'b1, 32'd2);

        // Kill during BUSY cycle 10
        fun = FUNC_DIVU; rs1 = 32'd1000; rs2 = 32'd3; valid[0] = 1'b1;
        @(posedge clk); #1;
        valid[0] = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        kill = 1'b1;
        @(negedge clk);
        check("kill_stall", 0, 32'(stall_o[0]), 32'd0);
        @(posedge clk); #1;
        kill = 1'b0;
        @(negedge clk);
        check("post_kill_idle", 0, 32'(stall_o[0]), 32'd0);
        @(posedge clk); #1;
        op(0, FUNC_DIVU, 32'd9, 32'd3, 0, 1'b1, 32'd3);

        // Reset mid-BUSY on each configuration
        for (int k = 0; k < 3; k++) begin
            fun = FUNC_DIV; rs1 = 32'd12345; rs2 = 32'd7; valid[k] = 1'b1;
            @(posedge clk); #1;
            valid[k] = 1'b0;
            repeat (3) begin @(posedge clk); #1; end
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            check("midrst_stall", k, 32'(stall_o[k]), 32'd0);
            check("midrst_rd", k, rd_o[k], 32'd0);
            @(posedge clk); #1;
        end

        // Random operands, biased toward small and special divisors
        for (int k = 0; k < 3; k++) begin
            for (int fi = 0; fi < 4; fi++) begin
                for (int i = 0; i < 40; i++) begin
                    logic [31:0] a, b;
                    a = $urandom;
                    b = $urandom;
                    if (i % 4 == 1) b = $urandom_range(0, 15);
                    if (i % 8 == 3) b = 32'd0;
                    if (i % 8 == 5) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                    if (i % 8 == 7) b = 32'h8000_0000;
                    op(k, 3'(4 + fi), a, b, 0, 1'b0, 32'd0);
                end
            end
        end

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
